// File: rtl/fir_pkg.sv
// Shared constants and capture-state encoding for the FIR filter and its
// capture buffer.
package fir_pkg;

  localparam int FIR_DATA_W = 10;
  localparam int FIR_IN_W   = 8;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_CAPTURE = 2'd2,
    CAP_READOUT = 2'd3
  } cap_state_t;

endpackage

// File: rtl/fir_capture_buffer_if.sv
// Sample-in stream and valid/ready readout port of the capture buffer.
// The slave modport is the capture buffer; master is the driving side.
interface fir_capture_buffer_if
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output din, din_valid, rd_ready,
    input  rd_data, rd_valid, rd_last
  );

  modport slave (
    input  din, din_valid, rd_ready,
    output rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/fir_cap_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Kept separate so the array maps cleanly onto block RAM.
module fir_cap_ram
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // registered read port
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_capture_buffer.sv
// Triggered capture of the FIR output stream followed by valid/ready replay.
// Optional macro FIR_CAP_PEAK_EN adds peak_max/peak_min tracking of the
// captured block.
module fir_capture_buffer
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  fir_capture_buffer_if.slave bus,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              cap_done
`ifdef FIR_CAP_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  cap_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic              rd_valid_reg, rd_valid_next;
  logic              cap_done_reg, cap_done_next;
  logic              wr_en;
  logic [DATA_W-1:0] ram_q;

  // The RAM is addressed with the next read pointer, so its registered
  // output always holds buf[rd_ptr_reg]; a stall re-reads the same word
  // and READOUT entry needs no bubble because address 0 is long written.
  fir_cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.din),
    .rd_addr (rd_ptr_next),
    .rd_data (ram_q)
  );

  // next-state, pointer and strobe logic; abort overrides every transition
  always_comb begin
    state_next    = state_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    rd_valid_next = rd_valid_reg;
    cap_done_next = 1'b0;
    wr_en         = 1'b0;
    if (abort) begin
      state_next    = CAP_IDLE;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      rd_valid_next = 1'b0;
    end else begin
      case (state_reg)
        CAP_IDLE: begin
          if (arm) state_next = CAP_ARMED;
        end
        CAP_ARMED: begin
          // the trigger sample itself lands at address 0
          if (bus.din_valid && (bus.din >= trig_level)) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            state_next  = CAP_CAPTURE;
          end
        end
        CAP_CAPTURE: begin
          if (bus.din_valid) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + 1'b1;
            if (wr_ptr_reg == LAST_ADDR) begin
              state_next    = CAP_READOUT;
              cap_done_next = 1'b1;
              rd_valid_next = 1'b1;
            end
          end
        end
        CAP_READOUT: begin
          if (rd_valid_reg && bus.rd_ready) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
            if (rd_ptr_reg == LAST_ADDR) begin
              state_next    = CAP_IDLE;
              rd_valid_next = 1'b0;
            end
          end
        end
        default: state_next = CAP_IDLE;
      endcase
    end
  end

  // state and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= CAP_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
      cap_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      rd_valid_reg <= rd_valid_next;
      cap_done_reg <= cap_done_next;
    end
  end

`ifdef FIR_CAP_PEAK_EN
  logic [DATA_W-1:0] peak_max_reg, peak_min_reg;

  // seed the peaks with the trigger sample, then track every stored sample
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_max_reg <= '0;
      peak_min_reg <= '0;
    end else if (wr_en && (state_reg == CAP_ARMED)) begin
      peak_max_reg <= bus.din;
      peak_min_reg <= bus.din;
    end else if (wr_en) begin
      if (bus.din > peak_max_reg) peak_max_reg <= bus.din;
      if (bus.din < peak_min_reg) peak_min_reg <= bus.din;
    end
  end

  assign peak_max = peak_max_reg;
  assign peak_min = peak_min_reg;
`endif

  // the RAM output is undefined before the first read, so mask it when idle
  assign bus.rd_data  = rd_valid_reg ? ram_q : '0;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_last  = rd_valid_reg && (rd_ptr_reg == LAST_ADDR);
  assign busy         = (state_reg != CAP_IDLE);
  assign cap_done     = cap_done_reg;

endmodule

// File: tb/tb_fir_capture_buffer.sv
// Directed bench for fir_capture_buffer: table-driven basic capture plus
// hand-written gapped, backpressure, abort and peak sequences.
module tb_fir_capture_buffer;
  import fir_pkg::*;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 16;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic              vld;
    logic              store;
    logic              done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic arm;
  logic abort;
  logic [DATA_W-1:0] trig_level;
  logic busy;
  logic cap_done;
`ifdef FIR_CAP_PEAK_EN
  logic [DATA_W-1:0] peak_max;
  logic [DATA_W-1:0] peak_min;
`endif

  fir_capture_buffer_if #(.DATA_W(DATA_W)) bus ();

  fir_capture_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .arm        (arm),
    .abort      (abort),
    .trig_level (trig_level),
    .busy       (busy),
    .cap_done   (cap_done)
`ifdef FIR_CAP_PEAK_EN
    ,
    .peak_max   (peak_max),
    .peak_min   (peak_min)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] stim_q[$];
  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input string tag);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk({tag, " busy after arm"}, busy, 1);
  endtask

  // contiguous valid samples from stim_q; trigger level must already pass stim_q[0]
  task automatic capture_contig(input string tag);
    exp_q.delete();
    do_arm(tag);
    foreach (stim_q[i]) begin
      bus.din       = stim_q[i];
      bus.din_valid = 1'b1;
      exp_q.push_back(stim_q[i]);
      tick();
      chk({tag, " cap_done"}, cap_done, int'(i == stim_q.size() - 1));
`ifdef FIR_CAP_PEAK_EN
      if (i == 0) begin
        chk({tag, " peak_max init"}, peak_max, stim_q[0]);
        chk({tag, " peak_min init"}, peak_min, stim_q[0]);
      end
`endif
    end
    bus.din_valid = 1'b0;
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: ready always with
  // arm and input samples pushed during readout. abort_after>=0 aborts there.
  task automatic readout(input int mode, input int abort_after, input string tag);
    int n = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [DATA_W-1:0] held = '0;
    while (n < DEPTH && cyc < 400) begin
      bus.rd_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (mode == 2) begin
        arm           = (cyc == 3);
        bus.din_valid = 1'b1;
        bus.din       = 10'd999;
      end
      if (stall) begin
        chk({tag, " hold rd_valid"}, bus.rd_valid, 1);
        chk({tag, " hold rd_data"}, bus.rd_data, held);
      end
      if (n == abort_after) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.rd_ready = 1'b0;
        chk({tag, " rd_valid after abort"}, bus.rd_valid, 0);
        chk({tag, " busy after abort"}, busy, 0);
        return;
      end
      stall = bus.rd_valid && !bus.rd_ready;
      held  = bus.rd_data;
      if (bus.rd_valid && bus.rd_ready) begin
        chk({tag, " rd_data"}, bus.rd_data, exp_q[n]);
        chk({tag, " rd_last"}, bus.rd_last, int'(n == DEPTH - 1));
        n++;
      end
      tick();
      cyc++;
    end
    arm           = 1'b0;
    bus.din_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    chk({tag, " handshakes"}, n, DEPTH);
    chk({tag, " rd_valid after last"}, bus.rd_valid, 0);
    chk({tag, " busy after last"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    arm           = 1'b0;
    abort         = 1'b0;
    trig_level    = '0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.rd_ready  = 1'b0;

    // basic capture stream: 5 and 10 below threshold, 40 not valid
    tbl[0] = '{10'd5,  1'b1, 1'b0, 1'b0};
    tbl[1] = '{10'd10, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{10'd40, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{10'd12, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{10'd15, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 14; k++)
      tbl[5 + k] = '{10'(16 + k), 1'b1, 1'b1, (k == 13)};

    // reset state
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset cap_done", cap_done, 0);
    chk("reset rd_valid", bus.rd_valid, 0);
    chk("reset rd_last", bus.rd_last, 0);
    chk("reset rd_data", bus.rd_data, 0);
`ifdef FIR_CAP_PEAK_EN
    chk("reset peak_max", peak_max, 0);
    chk("reset peak_min", peak_min, 0);
`endif

    // reset while ARMED returns to IDLE; later samples do not trigger
    do_arm("rst_armed");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_armed busy", busy, 0);
    chk("rst_armed rd_valid", bus.rd_valid, 0);
    chk("rst_armed cap_done", cap_done, 0);
    bus.din       = 10'd500;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    chk("rst_armed no trigger", busy, 0);

    // basic table-driven capture, trigger on din >= 12
    trig_level = 10'd12;
    exp_q.delete();
    do_arm("basic");
    foreach (tbl[k]) begin
      bus.din       = tbl[k].din;
      bus.din_valid = tbl[k].vld;
      if (tbl[k].store) exp_q.push_back(tbl[k].din);
      tick();
      chk("basic cap_done", cap_done, tbl[k].done);
      chk("basic busy", busy, 1);
    end
    bus.din_valid = 1'b0;
    readout(0, -1, "basic");

    // gapped input, trigger level 0, then backpressured readout
    trig_level = '0;
    exp_q.delete();
    do_arm("gap");
    begin
      int cnt = 0;
      for (int i = 0; i < 32; i++) begin
        bus.din_valid = (i % 2 == 0);
        bus.din       = 10'(100 + i);
        if (bus.din_valid) begin
          exp_q.push_back(bus.din);
          cnt++;
        end
        tick();
        chk("gap cap_done", cap_done, int'(bus.din_valid && cnt == DEPTH));
      end
    end
    bus.din_valid = 1'b0;
    readout(1, -1, "backpressure");

    // abort after 7 captured samples, coinciding valid sample ignored
    do_arm("abort");
    for (int i = 0; i < 7; i++) begin
      bus.din       = 10'(300 + i);
      bus.din_valid = 1'b1;
      tick();
    end
    abort   = 1'b1;
    bus.din = 10'd777;
    tick();
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort cap_done", cap_done, 0);
    chk("abort rd_valid", bus.rd_valid, 0);
    tick();
    bus.din_valid = 1'b0;
    chk("abort idle busy", busy, 0);
    chk("abort idle cap_done", cap_done, 0);

    // fresh capture after abort starts at address 0; arm during readout ignored
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) stim_q.push_back(10'(400 + i));
    capture_contig("recapture");
    readout(2, -1, "arm_in_readout");

    // abort in the middle of readout
    stim_q.delete();
    for (int i = 0; i < DEPTH; i++) stim_q.push_back(10'(600 + 3 * i));
    capture_contig("rdabort");
    readout(0, 5, "rdabort");

    // peak capture: 20,3,1000,7 then rising values
    stim_q.delete();
    stim_q.push_back(10'd20);
    stim_q.push_back(10'd3);
    stim_q.push_back(10'd1000);
    stim_q.push_back(10'd7);
    for (int i = 0; i < 12; i++) stim_q.push_back(10'(50 + i));
    capture_contig("peak");
`ifdef FIR_CAP_PEAK_EN
    chk("peak_max after capture", peak_max, 1000);
    chk("peak_min after capture", peak_min, 3);
`endif
    readout(0, -1, "peak");
`ifdef FIR_CAP_PEAK_EN
    chk("peak_max after readout", peak_max, 1000);
    chk("peak_min after readout", peak_min, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
